enable_pulse_gen: RTL and testbench



---
 rtl/enable_pulse_gen.sv | 85 ++++++++
 tb/tb_enable_pulse_gen.sv | 131 +++++++++++++
 2 files changed

// File: rtl/enable_pulse_gen.sv
// enable_pulse_gen: programmable single-cycle enable strobe generator with burst/continuous modes
module enable_pulse_gen #(
    parameter int DIV_WIDTH = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [CNT_WIDTH-1:0] burst_len,
    output logic                 enable,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] per_q, per_d, div_q, div_d, div_eff;
    logic [CNT_WIDTH-1:0] rem_q, rem_d;
    logic                 cont_q, cont_d, enable_q, enable_d, busy_q, busy_d, done_q, done_d;
    assign div_eff = (div == '0) ? DIV_WIDTH'(1) : div;
    assign enable  = enable_q;
    assign busy    = busy_q;
    assign done    = done_q;
    // next-state: the first pulse fires on the accepting edge, stop overrides pulse and completion
    always_comb begin
        state_d  = state_q;
        per_d    = per_q;
        div_d    = div_q;
        rem_d    = rem_q;
        cont_d   = cont_q;
        busy_d   = busy_q;
        enable_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d  = RUN;
                div_d    = div_eff;
                per_d    = div_eff - DIV_WIDTH'(1);
                rem_d    = burst_len - CNT_WIDTH'(1);
                cont_d   = (burst_len == '0);
                enable_d = 1'b1;
                busy_d   = 1'b1;
            end
            RUN: if (stop) begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end else if (per_q != '0) begin
                per_d = per_q - DIV_WIDTH'(1);
            end else if (cont_q || rem_q != '0) begin
                enable_d = 1'b1;
                per_d    = div_q - DIV_WIDTH'(1);
                rem_d    = cont_q ? rem_q : rem_q - CNT_WIDTH'(1);
            end else begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // state and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            per_q    <= '0;
            div_q    <= '0;
            rem_q    <= '0;
            cont_q   <= 1'b0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            per_q    <= per_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            cont_q   <= cont_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_enable_pulse_gen.sv
// tb_enable_pulse_gen: directed and randomized checks of enable_pulse_gen against a run-timeline model
module tb_enable_pulse_gen;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
    logic [7:0] div = '0, burst_len = '0;
    logic       enable, busy, done;
    int         total = 0, passed = 0;

    enable_pulse_gen #(.DIV_WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .div(div),
        .burst_len(burst_len), .enable(enable), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    endtask

    // Model: a run accepted at edge n0 pulses at n0 + k*D, completes at n0 + L*D
    typedef enum {M_IDLE, M_RUN, M_DONE} mode_t;
    mode_t mode = M_IDLE;
    int    cyc = 0, n0 = 0, dd = 1, ll = 0, t = 0;
    bit    cont = 1'b0, exp_en = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mode = M_IDLE;
            {exp_en, exp_busy, exp_done} = 3'b000;
        end else begin
            cyc++;
            case (mode)
                M_IDLE: if (start) begin
                    mode = M_RUN;
                    n0   = cyc;
                    dd   = (div == 0) ? 1 : int'(div);
                    ll   = int'(burst_len);
                    cont = (ll == 0);
                    {exp_en, exp_busy, exp_done} = 3'b110;
                end else {exp_en, exp_busy, exp_done} = 3'b000;
                M_RUN: begin
                    t = cyc - n0;
                    if (stop) begin
                        mode = M_IDLE;
                        {exp_en, exp_busy, exp_done} = 3'b000;
                    end else if (!cont && t == ll * dd) begin
                        mode = M_DONE;
                        {exp_en, exp_busy, exp_done} = 3'b001;
                    end else {exp_en, exp_busy, exp_done} = {(t % dd) == 0, 1'b1, 1'b0};
                end
                default: begin
                    mode = M_IDLE;
                    {exp_en, exp_busy, exp_done} = 3'b000;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("enable", enable, exp_en);
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
    end

    // Start at local edge 0; optional stop edge and second start edge (-1 = none); bit i of histories = after edge i
    task automatic run_dir(input string nm, input int d, input int bl, input int stp, input int s2,
                           input int n, input int ee, input int eb, input int edn);
        logic [31:0] he = '0, hb = '0, hd = '0;
        for (int i = 0; i < n; i++) begin
            start     = (i == 0) || (i == s2);
            stop      = (i == stp);
            div       = (i == 0) ? d[7:0] : 8'd1;
            burst_len = (i == 0) ? bl[7:0] : 8'd9;
            @(posedge clk);
            @(negedge clk);
            he[i] = enable;
            hb[i] = busy;
            hd[i] = done;
        end
        start = 1'b0;
        stop  = 1'b0;
        chk({nm, " enable"}, he, ee);
        chk({nm, " busy"}, hb, eb);
        chk({nm, " done"}, hd, edn);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset outputs", {enable, busy, done}, 0);
        rst = 1'b0;
        @(negedge clk);
        run_dir("div3_b4", 3, 4, -1, -1, 14, 'h249, 'hFFF, 'h1000);
        run_dir("div0_b3", 0, 3, -1, -1, 6, 'h7, 'h7, 'h8);
        run_dir("cont_stop", 2, 0, 9, -1, 12, 'h155, 'h1FF, 0);
        run_dir("start_in_run", 4, 2, -1, 2, 10, 'h11, 'hFF, 'h100);
        run_dir("stop_at_done", 5, 1, 5, -1, 8, 'h1, 'h1F, 0);
        run_dir("after_stop", 2, 2, -1, -1, 6, 'h5, 'hF, 'h10);
        start     = 1'b1;
        div       = 8'd3;
        burst_len = 8'd5;
        @(posedge clk);
        #2;
        chk("run before rst", {enable, busy, done}, 3'b110);
        rst = 1'b1;
        #1;
        chk("async rst", {enable, busy, done}, 0);
        start = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        run_dir("fresh", 1, 2, -1, -1, 5, 'h3, 'h3, 'h4);
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 3) == 0);
            stop      = ($urandom_range(0, 15) == 0);
            div       = 8'($urandom_range(0, 6));
            burst_len = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
